// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S microphone transmitter.
package i2s_pkg;

   localparam int unsigned default_w_sample  = 24;
   localparam int unsigned default_slot_bits = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a falling-edge detector.
module i2s_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic fall_c
);

   logic meta;
   logic sync;
   logic prev;

   // Synchronize din and keep one flop of history for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level  = sync;
   assign fall_c = prev & ~sync;

endmodule

// File: rtl/i2s_mic_transmitter.sv
// I2S slave transmitter: serializes one sample per frame into the selected WS slot.
module i2s_mic_transmitter
   import i2s_pkg::*;
#(
   parameter int unsigned w_sample  = default_w_sample,
   parameter int unsigned slot_bits = default_slot_bits
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lr,
   input  logic                sck,
   input  logic                ws,
   output logic                sd,
   output logic                sd_oe,
   input  logic [w_sample-1:0] sample_data,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                underrun,
   output logic                bit_error
);

   localparam int unsigned cnt_w = $clog2(slot_bits + 2);
   localparam int unsigned idx_w = (w_sample > 1) ? $clog2(w_sample) : 1;
   localparam logic [cnt_w-1:0] cnt_full = cnt_w'(slot_bits);
   localparam logic [cnt_w-1:0] cnt_sat  = cnt_w'(slot_bits + 1);
   localparam logic [idx_w-1:0] idx_msb  = idx_w'(w_sample - 1);

   state_t state;
   state_t state_next;

   logic sck_level_unused;
   logic fall_tick;
   logic ws_level;
   logic ws_fall_unused;

   logic                ws_prev;
   logic                ws_seen;
   logic                frame_seen;
   logic [cnt_w-1:0]    tick_cnt;
   logic [idx_w-1:0]    bit_idx;
   logic [w_sample-1:0] shreg;
   logic [w_sample-1:0] hold;
   logic                hold_full;
   logic [w_sample-1:0] last_sample;

   logic boundary_c;
   logic active_c;
   logic load_arm_c;
   logic capture_c;
   logic count_err_c;
   logic drive_c;
   logic abort_c;
   logic sd_next;
   logic oe_next;

   i2s_sync_edge u_sck_sync (
      .clk    (clk),
      .rst    (rst),
      .din    (sck),
      .level  (sck_level_unused),
      .fall_c (fall_tick)
   );

   i2s_sync_edge u_ws_sync (
      .clk    (clk),
      .rst    (rst),
      .din    (ws),
      .level  (ws_level),
      .fall_c (ws_fall_unused)
   );

   // Slot boundary detection; the first tick after reset only records ws
   always_comb begin
      boundary_c  = fall_tick & ws_seen & (ws_level ^ ws_prev);
      active_c    = (ws_level == lr);
      load_arm_c  = boundary_c & active_c;
      capture_c   = sample_valid & sample_ready;
      count_err_c = boundary_c & frame_seen & (tick_cnt != cnt_full);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; every boundary into the active slot re-arms
   always_comb begin
      state_next = state;
      if (fall_tick) begin
         case (state)
            IDLE: begin
               if (load_arm_c) state_next = ARM;
            end
            ARM: begin
               if (boundary_c) state_next = active_c ? ARM : PAD;
               else            state_next = SHIFT;
            end
            SHIFT: begin
               if (boundary_c)           state_next = active_c ? ARM : PAD;
               else if (bit_idx == '0)   state_next = PAD;
            end
            PAD: begin
               if (load_arm_c) state_next = ARM;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM output logic: next serial bit, enable and abort flag
   always_comb begin
      sd_next = sd;
      oe_next = sd_oe;
      drive_c = 1'b0;
      abort_c = 1'b0;
      if (fall_tick) begin
         sd_next = 1'b0;
         oe_next = 1'b0;
         case (state)
            ARM: begin
               if (!boundary_c) begin
                  sd_next = shreg[w_sample-1];
                  oe_next = 1'b1;
                  drive_c = 1'b1;
               end
            end
            SHIFT: begin
               if (boundary_c) begin
                  abort_c = 1'b1;
               end else if (bit_idx != '0) begin
                  sd_next = shreg[w_sample-1];
                  oe_next = 1'b1;
                  drive_c = 1'b1;
               end
            end
            default: begin
               sd_next = 1'b0;
               oe_next = 1'b0;
            end
         endcase
      end
   end

   // Registered serial outputs and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sd        <= 1'b0;
         sd_oe     <= 1'b0;
         bit_error <= 1'b0;
      end else begin
         sd        <= sd_next;
         sd_oe     <= oe_next;
         bit_error <= abort_c | count_err_c;
      end
   end

   // WS history and SCK-per-half-frame counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ws_prev    <= 1'b0;
         ws_seen    <= 1'b0;
         frame_seen <= 1'b0;
         tick_cnt   <= '0;
      end else if (fall_tick) begin
         ws_prev <= ws_level;
         ws_seen <= 1'b1;
         if (boundary_c) begin
            frame_seen <= 1'b1;
            tick_cnt   <= cnt_w'(1);
         end else if (tick_cnt != cnt_sat) begin
            tick_cnt <= tick_cnt + cnt_w'(1);
         end
      end
   end

   // Shift register load at ARM entry, then MSB-first shifting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg       <= '0;
         last_sample <= '0;
         bit_idx     <= '0;
         underrun    <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (load_arm_c) begin
            if (hold_full) begin
               shreg       <= hold;
               last_sample <= hold;
            end else begin
               shreg    <= last_sample;
               underrun <= 1'b1;
            end
         end else if (drive_c) begin
            shreg   <= shreg << 1;
            bit_idx <= (state == ARM) ? idx_msb : bit_idx - idx_w'(1);
         end
      end
   end

   // Single-entry holding register with valid/ready handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold         <= '0;
         hold_full    <= 1'b0;
         sample_ready <= 1'b1;
      end else if (capture_c) begin
         hold         <= sample_data;
         hold_full    <= 1'b1;
         sample_ready <= 1'b0;
      end else if (load_arm_c && hold_full) begin
         hold_full    <= 1'b0;
         sample_ready <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2s_mic_transmitter.sv
// Directed bench for i2s_mic_transmitter: SCK = 16 clk, 32-bit slots, 24-bit samples.
module tb_i2s_mic_transmitter;

   logic        clk = 1'b0;
   logic        rst;
   logic        lr;
   logic        sck;
   logic        ws;
   logic        sd;
   logic        sd_oe;
   logic [23:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic        underrun;
   logic        bit_error;

   int checks    = 0;
   int passes    = 0;
   int ur_total  = 0;
   int be_total  = 0;
   int rdy_total = 0;

   typedef struct {
      logic        lr;
      logic        offer;
      logic [23:0] data;
      logic [23:0] exp_word;
      int          exp_ur;
   } vec_t;

   vec_t vecs[7];

   i2s_mic_transmitter #(.w_sample(24), .slot_bits(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .lr           (lr),
      .sck          (sck),
      .ws           (ws),
      .sd           (sd),
      .sd_oe        (sd_oe),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .underrun     (underrun),
      .bit_error    (bit_error)
   );

   always #5 clk = ~clk;

   // Pulse and ready-cycle counters, sampled away from the active edge
   always @(negedge clk) begin
      if (underrun)     ur_total++;
      if (bit_error)    be_total++;
      if (sample_ready) rdy_total++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic sck_cycle(input logic wsv, output logic sd_e, output logic sd_r, output logic oe_r);
      @(negedge clk);
      sck = 1'b0;
      ws  = wsv;
      repeat (4) @(negedge clk);
      sd_e = sd;
      repeat (4) @(negedge clk);
      sck  = 1'b1;
      sd_r = sd;
      oe_r = sd_oe;
      repeat (7) @(negedge clk);
   endtask

   task automatic half_frame(input logic wsv, input int n,
                             output logic [31:0] sdv, output logic [31:0] sde, output logic [31:0] oev);
      logic e, r, o;
      sdv = '0;
      sde = '0;
      oev = '0;
      for (int i = 0; i < n; i++) begin
         sck_cycle(wsv, e, r, o);
         sdv[i] = r;
         sde[i] = e;
         oev[i] = o;
      end
   endtask

   function automatic logic [23:0] word_of(input logic [31:0] v);
      logic [23:0] wd;
      for (int i = 0; i < 24; i++) wd[23-i] = v[i+1];
      return wd;
   endfunction

   task automatic offer(input logic [23:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!sample_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!sample_ready) begin
         checks++;
         $display("FAIL offer_timeout: sample_ready stayed 0, required 1");
      end else begin
         sample_data  = d;
         sample_valid = 1'b1;
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] lsd, lse, loe, rsd, rse, roe;
      logic [31:0] asd, ase, aoe, isd, ioe;
      logic [31:0] acc;
      logic        e, r, o;
      logic [23:0] tmp;
      int ur0, be0, rdy0;

      vecs[0] = '{1'b0, 1'b1, 24'hA5F00F, 24'hA5F00F, 0};
      vecs[1] = '{1'b1, 1'b1, 24'h800001, 24'h800001, 0};
      vecs[2] = '{1'b1, 1'b1, 24'h7FFFFE, 24'h7FFFFE, 0};
      vecs[3] = '{1'b1, 1'b1, 24'h123456, 24'h123456, 0};
      vecs[4] = '{1'b1, 1'b0, 24'h000000, 24'h123456, 1};
      vecs[5] = '{1'b0, 1'b1, 24'h5A5A5A, 24'h5A5A5A, 0};
      vecs[6] = '{1'b0, 1'b0, 24'h000000, 24'h5A5A5A, 1};

      rst = 1'b1; lr = 1'b0; sck = 1'b1; ws = 1'b1;
      sample_valid = 1'b0; sample_data = '0;
      repeat (3) @(negedge clk);
      check("rst_sd",           32'(sd),           32'd0);
      check("rst_sd_oe",        32'(sd_oe),        32'd0);
      check("rst_sample_ready", 32'(sample_ready), 32'd1);
      check("rst_underrun",     32'(underrun),     32'd0);
      check("rst_bit_error",    32'(bit_error),    32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // short right half so the first real boundary is the exempt one
      half_frame(1'b1, 4, rsd, rse, roe);

      for (int k = 0; k < 7; k++) begin
         lr = vecs[k].lr;
         if (vecs[k].offer) offer(vecs[k].data);
         ur0 = ur_total;
         be0 = be_total;
         half_frame(1'b0, 32, lsd, lse, loe);
         half_frame(1'b1, 32, rsd, rse, roe);
         asd = vecs[k].lr ? rsd : lsd;
         ase = vecs[k].lr ? rse : lse;
         aoe = vecs[k].lr ? roe : loe;
         isd = vecs[k].lr ? lsd : rsd;
         ioe = vecs[k].lr ? loe : roe;
         check($sformatf("v%0d_word", k),       32'(word_of(asd)), 32'(vecs[k].exp_word));
         check($sformatf("v%0d_word_early", k), 32'(word_of(ase)), 32'(vecs[k].exp_word));
         check($sformatf("v%0d_oe_mask", k),    aoe,               32'h01FF_FFFE);
         check($sformatf("v%0d_idle_sd", k),    isd,               32'd0);
         check($sformatf("v%0d_idle_oe", k),    ioe,               32'd0);
         check($sformatf("v%0d_underrun", k),   32'(ur_total - ur0), 32'(vecs[k].exp_ur));
         check($sformatf("v%0d_bit_error", k),  32'(be_total - be0), 32'd0);
      end

      // short active slot: abort, then a full word in the next active slot
      lr = 1'b0;
      offer(24'hC3C3C3);
      be0 = be_total;
      half_frame(1'b0, 20, lsd, lse, loe);
      check("short_oe_mask", loe, 32'h000F_FFFE);
      check("short_word_top", 32'(word_of(lsd) >> 5), 32'(24'hC3C3C3 >> 5));
      half_frame(1'b1, 32, rsd, rse, roe);
      check("short_oe_after", roe, 32'd0);
      check("short_bit_error", 32'(be_total - be0), 32'd1);
      offer(24'h0F0F0F);
      be0 = be_total;
      ur0 = ur_total;
      half_frame(1'b0, 32, lsd, lse, loe);
      check("recover_word",      32'(word_of(lsd)), 32'h0F0F0F);
      check("recover_oe_mask",   loe,               32'h01FF_FFFE);
      check("recover_underrun",  32'(ur_total - ur0), 32'd0);
      check("recover_bit_error", 32'(be_total - be0), 32'd0);
      half_frame(1'b1, 32, rsd, rse, roe);

      // reset while bit 10 is on the line
      tmp = 24'h3C3C3C;
      offer(tmp);
      for (int i = 0; i < 15; i++) sck_cycle(1'b0, e, r, o);
      check("pre_rst_oe", 32'(sd_oe), 32'd1);
      check("pre_rst_sd", 32'(sd),    32'(tmp[10]));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_sd",    32'(sd),           32'd0);
      check("mid_rst_oe",    32'(sd_oe),        32'd0);
      check("mid_rst_ready", 32'(sample_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      be0 = be_total;
      acc = '0;
      for (int i = 15; i < 32; i++) begin
         sck_cycle(1'b0, e, r, o);
         acc[i] = o;
      end
      check("post_rst_left_oe", acc, 32'd0);
      half_frame(1'b1, 32, rsd, rse, roe);
      check("post_rst_right_oe", roe, 32'd0);
      ur0 = ur_total;
      half_frame(1'b0, 32, lsd, lse, loe);
      check("post_rst_word",      32'(word_of(lsd)), 32'd0);
      check("post_rst_oe_mask",   loe,               32'h01FF_FFFE);
      check("post_rst_underrun",  32'(ur_total - ur0), 32'd1);
      check("post_rst_bit_error", 32'(be_total - be0), 32'd0);
      half_frame(1'b1, 32, rsd, rse, roe);

      // sample_valid held high across the ARM entry
      offer(24'h69C3A5);
      @(negedge clk);
      sample_data  = 24'h13579B;
      sample_valid = 1'b1;
      rdy0 = rdy_total;
      half_frame(1'b0, 32, lsd, lse, loe);
      sample_valid = 1'b0;
      check("held_valid_ready_cycles", 32'(rdy_total - rdy0), 32'd1);
      check("held_valid_word1",        32'(word_of(lsd)),     32'h69C3A5);
      half_frame(1'b1, 32, rsd, rse, roe);
      ur0 = ur_total;
      half_frame(1'b0, 32, lsd, lse, loe);
      check("held_valid_word2",    32'(word_of(lsd)),   32'h13579B);
      check("held_valid_oe_mask",  loe,                 32'h01FF_FFFE);
      check("held_valid_underrun", 32'(ur_total - ur0), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
